// File: rtl/poly_arith_pkg.sv
// rtl/poly_arith_pkg.sv - shared coefficient types and writeback-buffer enums
//   COEFF_WIDTH / coeff_t : polynomial coefficient word
//   wb_state_e            : writeback buffer FSM states
//   PE_MAX_LATENCY        : worst-case butterfly PE pipeline depth
package poly_arith_pkg;

    localparam int COEFF_WIDTH = 16;
    typedef logic [COEFF_WIDTH-1:0] coeff_t;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_RUN,
        WB_DONE
    } wb_state_e;

    localparam int PE_MAX_LATENCY = 4;

endpackage

// File: rtl/coeff_pair_fifo.sv
// rtl/coeff_pair_fifo.sv - show-ahead FIFO of (u, v) coefficient pairs
//   clk, rst       : clock, synchronous active-low reset
//   push, wr_u/v   : write a pair (caller guarantees not full unless popping)
//   pop            : discard head (caller guarantees not empty)
//   rd_u/v         : head entry, valid whenever !empty
//   full, empty    : occupancy flags
//   count          : occupancy, 0..DEPTH
module coeff_pair_fifo
    import poly_arith_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  coeff_t                     wr_u,
    input  coeff_t                     wr_v,
    output coeff_t                     rd_u,
    output coeff_t                     rd_v,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [2*COEFF_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {wr_u, wr_v};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (count == (AW+1)'(DEPTH));
    assign {rd_u, rd_v} = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pe_wb_buffer.sv
// rtl/pe_wb_buffer.sv - PE result writeback buffer with butterfly address generation
//   clk, rst                    : clock, synchronous active-low reset
//   start_i, base_addr_i, len_i,
//   pair_count_i                : job setup, accepted in IDLE only
//   u_i, v_i, valid_i           : PE result stream (no backpressure)
//   stall_o                     : stop issuing to the PE
//   wr_valid_o, wr_ready_i,
//   wr_addr_u/v_o, wr_data_u/v_o: pair write port to polynomial memory
//   done_o                      : one-cycle pulse after last pair written
//   err_o                       : sticky dropped-result flag, cleared by start
module pe_wb_buffer
    import poly_arith_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int SKID       = PE_MAX_LATENCY,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    input  logic [ADDR_WIDTH-1:0] pair_count_i,
    input  coeff_t                u_i,
    input  coeff_t                v_i,
    input  logic                  valid_i,
    output logic                  stall_o,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_u_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_v_o,
    output coeff_t                wr_data_u_o,
    output coeff_t                wr_data_v_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_e             state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] len_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] pairs_r;
    logic [ADDR_WIDTH-1:0] j_r;
    logic [ADDR_WIDTH-1:0] j_inc;
    logic [ADDR_WIDTH-1:0] j_next;
    logic                  err_r;

    coeff_t                head_u;
    coeff_t                head_v;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         occ;

    logic                  running;
    logic                  hs;
    logic                  push;
    logic                  drop;

    assign running    = (state == WB_RUN);
    assign wr_valid_o = running && !empty;
    assign hs         = wr_valid_o && wr_ready_i;
    // A full FIFO can still take a result when the head leaves this cycle.
    assign push       = valid_i && running && (!full || hs);
    assign drop       = valid_i && !push;

    coeff_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (hs),
        .wr_u  (u_i),
        .wr_v  (v_i),
        .rd_u  (head_u),
        .rd_v  (head_v),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    // Leaving SKID free slots covers every result still inside the PE.
    assign stall_o = (occ >= CW'(DEPTH - SKID));

    // Step within a block of len, then skip the partner block of len.
    assign j_inc  = j_r + ADDR_WIDTH'(1);
    assign j_next = (((j_inc - base_r) & (len_r - ADDR_WIDTH'(1))) == '0)
                    ? (j_r + len_r + ADDR_WIDTH'(1)) : j_inc;

    assign wr_addr_u_o = j_r;
    assign wr_addr_v_o = j_r + len_r;
    // Gate the unreset storage so the data port reads zero when idle.
    assign wr_data_u_o = wr_valid_o ? head_u : '0;
    assign wr_data_v_o = wr_valid_o ? head_v : '0;
    assign done_o      = (state == WB_DONE);
    assign err_o       = err_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= WB_IDLE;
            base_r  <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
            pairs_r <= '0;
            j_r     <= '0;
            err_r   <= 1'b0;
        end else begin
            if (state == WB_IDLE && start_i) begin
                err_r <= drop;
            end else if (drop) begin
                err_r <= 1'b1;
            end

            case (state)
                WB_IDLE: begin
                    if (start_i) begin
                        base_r  <= base_addr_i;
                        len_r   <= len_i;
                        cnt_r   <= pair_count_i;
                        j_r     <= base_addr_i;
                        pairs_r <= '0;
                        state   <= (pair_count_i == '0) ? WB_DONE : WB_RUN;
                    end
                end
                WB_RUN: begin
                    if (hs) begin
                        j_r     <= j_next;
                        pairs_r <= pairs_r + ADDR_WIDTH'(1);
                        if (pairs_r == cnt_r - ADDR_WIDTH'(1)) begin
                            state <= WB_DONE;
                        end
                    end
                end
                WB_DONE: begin
                    state <= WB_IDLE;
                end
                default: begin
                    state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule
